// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB command encodings and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam logic [1:0] PMODE_NOP   = 2'b00;
    localparam logic [1:0] PMODE_READ  = 2'b10;
    localparam logic [1:0] PMODE_WRITE = 2'b11;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Combinational round-robin search starting at rr_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any_req
);

    localparam int IDX_W = $clog2(NREQ);

    always_comb begin : p_search
        logic [IDX_W-1:0] w_idx;
        w_idx     = '0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        // Visit requesters in priority order rr_ptr, rr_ptr+1, ... modulo NREQ.
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IDX_W'((int'(rr_ptr) + i) % NREQ);
            if (!any_req && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                any_req      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Round-robin sharing of one apb_master between NREQ requesters,
//               with registered command/response paths and a BUSY watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSEL_WIDTH = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                       PCLK_i,
    input  logic                       PRESET_i,
    input  logic [NREQ-1:0]            REQ_i,
    input  logic [NREQ-1:0]            REQ_WRITE_i,
    input  logic [NREQ*ADDR_WIDTH-1:0] REQ_ADDR_i,
    input  logic [NREQ*DATA_WIDTH-1:0] REQ_WDATA_i,
    input  logic [NREQ*PSEL_WIDTH-1:0] REQ_PSEL_i,
    output logic [NREQ-1:0]            REQ_GNT_o,
    output logic [NREQ-1:0]            REQ_DONE_o,
    output logic [DATA_WIDTH-1:0]      REQ_RDATA_o,
    output logic                       REQ_ERR_o,
    output logic                       TIMEOUT_o,
    output logic [1:0]                 M_PMODE_o,
    output logic [ADDR_WIDTH-1:0]      M_PADDR_o,
    output logic [DATA_WIDTH-1:0]      M_PWDATA_o,
    output logic [PSEL_WIDTH-1:0]      M_PSEL_o,
    input  logic                       M_PENABLE_i,
    input  logic                       M_PREADY_i,
    input  logic [DATA_WIDTH-1:0]      M_PRDATA_i,
    input  logic                       M_PSLVERR_i
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] c_wd_limit = WD_W'(TIMEOUT);

    arb_state_t              r_state, w_state_n;
    logic [1:0]              r_mode, w_mode_n;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_n;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_n;
    logic [PSEL_WIDTH-1:0]   r_psel, w_psel_n;
    logic [NREQ-1:0]         r_gnt, w_gnt_n;
    logic [NREQ-1:0]         r_done, w_done_n;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_n;
    logic                    r_err, w_err_n;
    logic                    r_timeout, w_timeout_n;
    logic [IDX_W-1:0]        r_rr, w_rr_n;
    logic [IDX_W-1:0]        r_owner, w_owner_n;
    logic [WD_W-1:0]         r_wd, w_wd_n;

    logic [NREQ-1:0]         w_grant;
    logic [IDX_W-1:0]        w_grant_idx;
    logic                    w_any_req;
    logic                    w_complete;
    logic                    w_expire;

    apb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req       (REQ_i),
        .rr_ptr    (r_rr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    assign w_complete = M_PENABLE_i & M_PREADY_i;
    assign w_expire   = (TIMEOUT != 0) && (r_wd == c_wd_limit);

    always_comb begin
        w_state_n   = r_state;
        w_mode_n    = r_mode;
        w_addr_n    = r_addr;
        w_wdata_n   = r_wdata;
        w_psel_n    = r_psel;
        w_gnt_n     = '0;
        w_done_n    = '0;
        w_rdata_n   = r_rdata;
        w_err_n     = r_err;
        w_timeout_n = 1'b0;
        w_rr_n      = r_rr;
        w_owner_n   = r_owner;
        w_wd_n      = r_wd;

        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (w_grant[k]) begin
                            w_mode_n  = REQ_WRITE_i[k] ? PMODE_WRITE : PMODE_READ;
                            w_addr_n  = REQ_ADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                            w_wdata_n = REQ_WDATA_i[k*DATA_WIDTH +: DATA_WIDTH];
                            w_psel_n  = REQ_PSEL_i[k*PSEL_WIDTH +: PSEL_WIDTH];
                        end
                    end
                    w_gnt_n   = w_grant;
                    w_owner_n = w_grant_idx;
                    w_wd_n    = '0;
                    w_state_n = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A real completion takes precedence over an expiring watchdog.
                if (w_complete || w_expire) begin
                    w_done_n[r_owner] = 1'b1;
                    w_rdata_n   = (w_complete && !r_mode[0]) ? M_PRDATA_i : '0;
                    w_err_n     = w_complete ? M_PSLVERR_i : 1'b1;
                    w_timeout_n = !w_complete;
                    w_mode_n    = PMODE_NOP;
                    w_rr_n      = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                    w_state_n   = ARB_IDLE;
                end else if (r_wd != '1) begin
                    w_wd_n = r_wd + 1'b1;
                end
            end
            default: w_state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge PCLK_i) begin
        if (!PRESET_i) begin
            r_state   <= ARB_IDLE;
            r_mode    <= PMODE_NOP;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_psel    <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_rr      <= '0;
            r_owner   <= '0;
            r_wd      <= '0;
        end else begin
            r_state   <= w_state_n;
            r_mode    <= w_mode_n;
            r_addr    <= w_addr_n;
            r_wdata   <= w_wdata_n;
            r_psel    <= w_psel_n;
            r_gnt     <= w_gnt_n;
            r_done    <= w_done_n;
            r_rdata   <= w_rdata_n;
            r_err     <= w_err_n;
            r_timeout <= w_timeout_n;
            r_rr      <= w_rr_n;
            r_owner   <= w_owner_n;
            r_wd      <= w_wd_n;
        end
    end

    assign REQ_GNT_o   = r_gnt;
    assign REQ_DONE_o  = r_done;
    assign REQ_RDATA_o = r_rdata;
    assign REQ_ERR_o   = r_err;
    assign TIMEOUT_o   = r_timeout;
    assign M_PMODE_o   = r_mode;
    assign M_PADDR_o   = r_addr;
    assign M_PWDATA_o  = r_wdata;
    assign M_PSEL_o    = r_psel;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Directed and randomized checks of apb_master_arbiter against a
//               transaction-level round-robin / latency model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req, req_write, req_psel;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  gnt, done;
    logic [7:0]  rdata;
    logic        err, tmo;
    logic [1:0]  m_pmode;
    logic [7:0]  m_paddr, m_pwdata;
    logic        m_psel;
    logic        m_penable, m_pready, m_pslverr;
    logic [7:0]  m_prdata;

    int          vectors = 0;
    int          miscompares = 0;
    int          model_rr = 0;
    logic [7:0]  last_rdata = 8'h00;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .NREQ (2), .ADDR_WIDTH (8), .DATA_WIDTH (8), .PSEL_WIDTH (1), .TIMEOUT (T)
    ) dut (
        .PCLK_i      (clk),
        .PRESET_i    (rstn),
        .REQ_i       (req),
        .REQ_WRITE_i (req_write),
        .REQ_ADDR_i  (req_addr),
        .REQ_WDATA_i (req_wdata),
        .REQ_PSEL_i  (req_psel),
        .REQ_GNT_o   (gnt),
        .REQ_DONE_o  (done),
        .REQ_RDATA_o (rdata),
        .REQ_ERR_o   (err),
        .TIMEOUT_o   (tmo),
        .M_PMODE_o   (m_pmode),
        .M_PADDR_o   (m_paddr),
        .M_PWDATA_o  (m_pwdata),
        .M_PSEL_o    (m_psel),
        .M_PENABLE_i (m_penable),
        .M_PREADY_i  (m_pready),
        .M_PRDATA_i  (m_prdata),
        .M_PSLVERR_i (m_pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        req = 2'b00;
        m_penable = 1'b0;
        m_pready = 1'b0;
        m_pslverr = 1'b0;
        m_prdata = 8'h00;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_timeout", 32'(tmo), 32'd0);
            chk("rst_pmode", 32'(m_pmode), 32'd0);
            chk("rst_paddr", 32'(m_paddr), 32'd0);
            chk("rst_pwdata", 32'(m_pwdata), 32'd0);
            chk("rst_psel", 32'(m_psel), 32'd0);
        end
        rstn = 1'b1;
        model_rr = 0;
        last_rdata = 8'h00;
        last_err = 1'b0;
    endtask

    task automatic set_cmd(input int k, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, input logic ps);
        req_write[k] = wr;
        req_addr[k*8 +: 8] = a;
        req_wdata[k*8 +: 8] = d;
        req_psel[k] = ps;
    endtask

    task automatic rand_cmds();
        req_write = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_psel  = 2'($urandom);
    endtask

    // One complete transaction: arbitration decided by the model pointer, the
    // slave emulated as SETUP then ACCESS with `waits` stalled cycles.
    task automatic transfer(input logic [1:0] mask, input int waits, input logic [7:0] prd,
                            input logic serr, input bit stuck);
        int         k;
        int         cc;
        int         done_cyc;
        bit         to;
        logic       wr, ps;
        logic [7:0] a, d, exp_rd;
        logic       exp_err;
        logic [1:0] oh;

        chk("idle_pmode_nop", 32'(m_pmode), 32'd0);
        k = -1;
        for (int i = 0; i < 2; i++)
            if (k < 0 && mask[(model_rr + i) % 2]) k = (model_rr + i) % 2;
        oh = 2'(1 << k);
        wr = req_write[k];
        a  = req_addr[k*8 +: 8];
        d  = req_wdata[k*8 +: 8];
        ps = req_psel[k];
        cc = 1 + waits;
        to = stuck || (cc > T);
        done_cyc = to ? T + 1 : cc + 1;

        req = mask;
        tick();
        for (int j = 0; j < done_cyc; j++) begin
            chk("gnt", 32'(gnt), (j == 0) ? 32'(oh) : 32'd0);
            chk("busy_done", 32'(done), 32'd0);
            chk("busy_timeout", 32'(tmo), 32'd0);
            chk("pmode", 32'(m_pmode), 32'({1'b1, wr}));
            chk("paddr", 32'(m_paddr), 32'(a));
            chk("pwdata", 32'(m_pwdata), 32'(d));
            chk("psel", 32'(m_psel), 32'(ps));
            chk("rdata_hold", 32'(rdata), 32'(last_rdata));
            chk("err_hold", 32'(err), 32'(last_err));
            if (j == 0) begin
                req[k] = 1'b0;
                set_cmd(k, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            end
            m_penable = (j > 0);
            m_pready  = (j == 0) ? 1'($urandom) : (!stuck && j == cc);
            m_prdata  = (j == cc) ? prd : 8'($urandom);
            m_pslverr = (j == cc) ? serr : 1'($urandom);
            tick();
        end
        exp_rd  = (!to && !wr) ? prd : 8'h00;
        exp_err = to ? 1'b1 : serr;
        chk("done", 32'(done), 32'(oh));
        chk("done_gnt", 32'(gnt), 32'd0);
        chk("timeout", 32'(tmo), 32'(to));
        chk("done_pmode_nop", 32'(m_pmode), 32'd0);
        chk("rdata", 32'(rdata), 32'(exp_rd));
        chk("err", 32'(err), 32'(exp_err));
        m_penable = 1'b0;
        m_pready = 1'b0;
        last_rdata = exp_rd;
        last_err = exp_err;
        model_rr = (k + 1) % 2;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rstn = 1'b0;
        req = 2'b00;
        rand_cmds();
        m_penable = 1'b0;
        m_pready = 1'b0;
        m_prdata = 8'h00;
        m_pslverr = 1'b0;
        do_reset(2);

        // Zero-wait write from requester 0
        set_cmd(0, 1'b1, 8'h15, 8'h28, 1'b1);
        transfer(2'b01, 0, 8'($urandom), 1'b0, 1'b0);

        // Both requesters held: alternating grants from a fresh pointer
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            rand_cmds();
            transfer(2'b11, $urandom_range(0, 3), 8'($urandom), 1'($urandom), 1'b0);
        end

        // Read from requester 1 with three wait states
        set_cmd(1, 1'b0, 8'h03, 8'($urandom), 1'b1);
        transfer(2'b10, 3, 8'h5A, 1'b0, 1'b0);

        // Slave error, then a clean transfer
        set_cmd(0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
        transfer(2'b01, 1, 8'($urandom), 1'b1, 1'b0);
        set_cmd(1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
        transfer(2'b10, 0, 8'($urandom), 1'b0, 1'b0);

        // Watchdog with PREADY stuck low, then normal service resumes
        rand_cmds();
        transfer(2'b11, 0, 8'($urandom), 1'b0, 1'b1);
        rand_cmds();
        transfer(2'b11, 2, 8'($urandom), 1'b0, 1'b0);

        // Watchdog boundary: completion exactly at the limit wins, one later loses
        rand_cmds();
        transfer(2'b01, T - 1, 8'($urandom), 1'($urandom), 1'b0);
        rand_cmds();
        transfer(2'b10, T, 8'($urandom), 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rand_cmds();
            transfer(2'($urandom_range(1, 3)), $urandom_range(0, T + 1), 8'($urandom),
                     1'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a transfer, with the pointer parked at 1
        rand_cmds();
        transfer(2'b01, 0, 8'($urandom), 1'b0, 1'b0);
        req = 2'b01;
        tick();
        chk("midbusy_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        m_penable = 1'b0;
        tick();
        m_penable = 1'b1;
        tick();
        do_reset(2);
        rand_cmds();
        transfer(2'b11, 1, 8'($urandom), 1'b0, 1'b0);
        rand_cmds();
        transfer(2'b10, 0, 8'($urandom), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
